ahbl_cmd_master: RTL and testbench
==================================

# ahbl_cmd_master

Request-driven AHB-Lite initiator that turns a simple valid/ready command stream into pipelined AHB-Lite single transfers (NONSEQ only) on the system bus. It drives the same bus the address splitter and register slaves sit on, and replaces the free-running test master in the SoC. Commands are buffered in a small FIFO. Narrow writes are lane-replicated and narrow reads are lane-extracted. Each completed transfer returns one response beat.

## Interface
Parameters:
- FIFO_DEPTH, 2, request FIFO entries; power of 2, ≥2

Ports:
- HCLK  in  1  bus clock; all state updates on its rising edge
- HRESET  in  1  synchronous, active-high reset
- req_valid  in  1  command present
- req_ready  out  1  FIFO can accept the command (not full)
- req_write  in  1  1 = write, 0 = read
- req_addr  in  32  byte address
- req_size  in  3  0 = byte, 1 = half, 2 = word; values >2 are treated as 2
- req_wdata  in  32  right-justified write data
- rsp_valid  out  1  one-cycle pulse per completed transfer
- rsp_write  out  1  echo of the command type
- rsp_rdata  out  32  right-justified, zero-extended read data; 0 for writes
- busy  out  1  FIFO non-empty, data phase pending, or response pending
- HADDR  out  32  address phase address
- HTRANS  out  2  2'b10 NONSEQ or 2'b00 IDLE
- HSIZE  out  3  transfer size
- HWRITE  out  1  transfer direction
- HWDATA  out  32  data phase write data
- HREADY  in  1  bus ready (splitter-muxed HREADYOUT)
- HRDATA  in  32  bus read data

## Operation
- **Accept.** A command is pushed at an edge where req_valid && req_ready. req_ready = !full, computed from the pre-edge count only. A full FIFO is not ready even if it pops the same cycle.
- **Size and address normalisation at push.** s = min(req_size, 2). Stored address = req_addr with bit 0 cleared for s = 1, and bits [1:0] cleared for s = 2.
- **Write lane replication at push:**
  - s = 0: {4{wdata[7:0]}}
  - s = 1: {2{wdata[15:0]}}
  - s = 2: wdata unchanged
- **Address phase.** Whenever the FIFO is non-empty, drive the head entry: HTRANS = 2'b10, and HADDR/HSIZE/HWRITE from the entry. When the FIFO is empty, HTRANS = 0 and HADDR/HSIZE/HWRITE = 0. Outputs come straight from FIFO storage and are stable while HREADY = 0.
- **Pop.** The head pops at an edge where it is non-empty and HREADY = 1. At that edge the data-phase register loads: dp_valid = 1, write flag, addr[1:0], size, wdata.
- **Data phase:**
  - HWDATA = dp_wdata while dp_valid && dp_write; 0 otherwise.
  - The phase completes at an edge with dp_valid && HREADY = 1.
  - At that edge: rsp_valid <= 1, rsp_write <= dp_write.
  - For reads, rsp_rdata <= HRDATA lane selected by addr[1:0], zero-extended:
    - s = 0: byte at bits [8·a+7 : 8·a], a = addr[1:0]
    - s = 1: half at bits [16·addr[1]+15 : 16·addr[1]]
    - s = 2: full word
  - For writes, rsp_rdata <= 0.
  - dp_valid clears unless a new pop occurs at the same edge (back-to-back pipelining).
- **No backpressure on responses.** The consumer must take rsp_valid when it is offered. rsp_valid is high for exactly one cycle per transfer, in command order.
- **Simultaneous push and pop** when not full: count is unchanged and both take effect. Pointers wrap modulo FIFO_DEPTH.

## Timing
- **Reset (HRESET high at an edge):** FIFO emptied, dp_valid = 0, rsp_valid = 0, rsp_write = 0, rsp_rdata = 0. Outputs during and after reset:
  - HTRANS = 0, HADDR = 0, HSIZE = 0, HWRITE = 0, HWDATA = 0, busy = 0.
  - req_ready = 0 while HRESET is high and 1 in the first cycle after release.
- **Reset mid-transfer:** in-flight and queued commands are discarded with no response. The bus goes to IDLE in the cycle after the reset edge.
- **Zero-wait latency:**
  - accept edge E0
  - address phase in the cycle after E0
  - data phase in the cycle after E1
  - rsp_valid high in the cycle after E2, i.e. 3 cycles after acceptance
- **Throughput:** one transfer per cycle when commands arrive every cycle and HREADY = 1.
- **Wait states:** each HREADY = 0 cycle extends the current address and data phases by one cycle. All bus outputs hold during a wait state.

## Test plan
- Write word 0xDEADBEEF to 0x0000_0004 with HREADY = 1 → HTRANS = 2'b10, HADDR = 0x4, HSIZE = 2, HWRITE = 1 one cycle after accept; HWDATA = 0xDEADBEEF the next cycle; rsp_valid pulse with rsp_write = 1, rsp_rdata = 0 three cycles after accept.
- Byte read from 0x0000_0013 with HRDATA = 0xAABBCCDD → HADDR = 0x13, HSIZE = 0; rsp_rdata = 0x000000AA. Half read at 0x12 → 0x0000AABB. Byte write of 0x5A at 0x11 → HWDATA = 0x5A5A5A5A.
- Four back-to-back word reads with HREADY held 1 → HTRANS = NONSEQ on 4 consecutive cycles; four consecutive rsp_valid pulses in order; req_ready drops to 0 when the FIFO holds 2 entries.
- HREADY = 0 for 2 cycles during a write data phase → HADDR, HTRANS and HWDATA held; rsp_valid delayed by exactly 2 cycles.
- Assert HRESET while 2 commands are queued and 1 is in data phase → next cycle HTRANS = 0, busy = 0, no rsp_valid; the next command accepted after reset runs normally.

Source files
------------

// File: rtl/ahbl_cmd_master.sv
// ahbl_cmd_master
//   Request-driven AHB-Lite initiator. Commands arriving on a valid/ready
//   stream are normalised (size clamp, address alignment, write-lane
//   replication) and buffered in a small FIFO. The FIFO head drives the
//   address phase directly; a single data-phase register tracks the transfer
//   in flight so that NONSEQ transfers pipeline back to back. Every
//   completed data phase produces a one-cycle response beat.
//
// Ports
//   HCLK, HRESET            clock, synchronous active-high reset
//   req_valid/req_ready     command handshake (ready = FIFO not full)
//   req_write/addr/size/wdata  command fields, wdata right-justified
//   rsp_valid/write/rdata   response beat, rdata right-justified, 0 on writes
//   busy                    FIFO non-empty, data phase or response pending
//   HADDR/HTRANS/HSIZE/HWRITE/HWDATA  AHB-Lite initiator outputs
//   HREADY, HRDATA          AHB-Lite bus inputs
module ahbl_cmd_master #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_write,
  output logic [31:0] rsp_rdata,
  output logic        busy,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA
);

  localparam int              AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]     DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0]   PTR_ONE = AW'(1);
  localparam logic [AW:0]     CNT_ONE = (AW+1)'(1);
  localparam logic [1:0]      TR_IDLE   = 2'b00;
  localparam logic [1:0]      TR_NONSEQ = 2'b10;

  // Sizes above word are treated as word.
  function automatic logic [1:0] norm_size(input logic [2:0] size);
    logic [1:0] s;
    s = (size > 3'd2) ? 2'd2 : size[1:0];
    return s;
  endfunction

  function automatic logic [31:0] norm_addr(input logic [31:0] addr, input logic [1:0] s);
    logic [31:0] a;
    case (s)
      2'd1:    a = {addr[31:1], 1'b0};
      2'd2:    a = {addr[31:2], 2'b00};
      default: a = addr;
    endcase
    return a;
  endfunction

  // Replicate narrow write data so every byte lane carries it; the slave
  // picks the lane(s) matching HADDR/HSIZE.
  function automatic logic [31:0] replicate(input logic [31:0] wdata, input logic [1:0] s);
    logic [31:0] w;
    case (s)
      2'd0:    w = {4{wdata[7:0]}};
      2'd1:    w = {2{wdata[15:0]}};
      default: w = wdata;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] lane_extract(input logic [31:0] rdata, input logic [1:0] s,
                                               input logic [1:0] lane);
    logic [31:0] sh;
    logic [31:0] r;
    case (s)
      2'd0: begin
        sh = rdata >> {lane, 3'b000};
        r  = {24'd0, sh[7:0]};
      end
      2'd1: begin
        sh = rdata >> {lane[1], 4'b0000};
        r  = {16'd0, sh[15:0]};
      end
      default: begin
        sh = rdata;
        r  = sh;
      end
    endcase
    return r;
  endfunction

  logic [31:0]   fifo_addr_q  [FIFO_DEPTH];
  logic [31:0]   fifo_addr_d  [FIFO_DEPTH];
  logic [1:0]    fifo_size_q  [FIFO_DEPTH];
  logic [1:0]    fifo_size_d  [FIFO_DEPTH];
  logic          fifo_write_q [FIFO_DEPTH];
  logic          fifo_write_d [FIFO_DEPTH];
  logic [31:0]   fifo_wdata_q [FIFO_DEPTH];
  logic [31:0]   fifo_wdata_d [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic          dp_valid_q, dp_valid_d;
  logic          dp_write_q, dp_write_d;
  logic [1:0]    dp_lane_q,  dp_lane_d;
  logic [1:0]    dp_size_q,  dp_size_d;
  logic [31:0]   dp_wdata_q, dp_wdata_d;

  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_write_q, rsp_write_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;

  logic          empty, full, push, pop, dp_done;
  logic [1:0]    push_size;

  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_C);
  // Ready depends only on the pre-edge count: a full FIFO that pops this
  // cycle still refuses the command.
  assign req_ready = !full && !HRESET;
  assign push      = req_valid && req_ready;
  assign pop       = !empty && HREADY;
  assign dp_done   = dp_valid_q && HREADY;
  assign push_size = norm_size(req_size);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    fifo_addr_d  = fifo_addr_q;
    fifo_size_d  = fifo_size_q;
    fifo_write_d = fifo_write_q;
    fifo_wdata_d = fifo_wdata_q;
    dp_valid_d   = dp_valid_q;
    dp_write_d   = dp_write_q;
    dp_lane_d    = dp_lane_q;
    dp_size_d    = dp_size_q;
    dp_wdata_d   = dp_wdata_q;
    rsp_valid_d  = dp_done;
    rsp_write_d  = rsp_write_q;
    rsp_rdata_d  = rsp_rdata_q;

    if (push) begin
      fifo_addr_d[wr_ptr_q]  = norm_addr(req_addr, push_size);
      fifo_size_d[wr_ptr_q]  = push_size;
      fifo_write_d[wr_ptr_q] = req_write;
      fifo_wdata_d[wr_ptr_q] = replicate(req_wdata, push_size);
      wr_ptr_d               = wr_ptr_q + PTR_ONE;
    end

    // A pop reloads the data-phase register, so a completing transfer is
    // replaced in the same edge without a bubble.
    if (pop) begin
      dp_valid_d = 1'b1;
      dp_write_d = fifo_write_q[rd_ptr_q];
      dp_lane_d  = fifo_addr_q[rd_ptr_q][1:0];
      dp_size_d  = fifo_size_q[rd_ptr_q];
      dp_wdata_d = fifo_wdata_q[rd_ptr_q];
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
    end else if (dp_done) begin
      dp_valid_d = 1'b0;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (dp_done) begin
      rsp_write_d = dp_write_q;
      rsp_rdata_d = dp_write_q ? 32'd0 : lane_extract(HRDATA, dp_size_q, dp_lane_q);
    end
  end

  // Control state and response beat
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dp_valid_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dp_valid_q  <= dp_valid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // FIFO storage and data-phase payload; qualified by count/dp_valid
  always_ff @(posedge HCLK) begin
    fifo_addr_q  <= fifo_addr_d;
    fifo_size_q  <= fifo_size_d;
    fifo_write_q <= fifo_write_d;
    fifo_wdata_q <= fifo_wdata_d;
    dp_write_q   <= dp_write_d;
    dp_lane_q    <= dp_lane_d;
    dp_size_q    <= dp_size_d;
    dp_wdata_q   <= dp_wdata_d;
  end

  // Address phase comes straight from the FIFO head, so it holds across
  // wait states without any extra registers.
  assign HTRANS    = empty ? TR_IDLE : TR_NONSEQ;
  assign HADDR     = empty ? 32'd0 : fifo_addr_q[rd_ptr_q];
  assign HSIZE     = empty ? 3'd0 : {1'b0, fifo_size_q[rd_ptr_q]};
  assign HWRITE    = empty ? 1'b0 : fifo_write_q[rd_ptr_q];
  assign HWDATA    = (dp_valid_q && dp_write_q) ? dp_wdata_q : 32'd0;

  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = !empty || dp_valid_q || rsp_valid_q;

endmodule

// File: tb/tb_ahbl_cmd_master.sv
// tb_ahbl_cmd_master
//   Bench for ahbl_cmd_master. A behavioural AHB-Lite slave with a small
//   word memory answers the bus; a byte-array reference memory updated in
//   command order predicts every response. Directed vectors, multi-cycle
//   sequences (pipelining, wait states, reset mid-transfer) and a random
//   run are applied.
module tb_ahbl_cmd_master;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic        rsp_valid, rsp_write, busy;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE, HREADY;

  always #5 HCLK = ~HCLK;

  ahbl_cmd_master #(.FIFO_DEPTH(2)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .busy(busy),
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA)
  );

  int checks   = 0;
  int failures = 0;
  int rsp_seen = 0;

  typedef struct {
    logic        wr;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] preload;
    logic [31:0] exp_haddr;
    logic [2:0]  exp_hsize;
    logic [31:0] exp_hwdata;
    logic [31:0] exp_rdata;
  } vec_t;

  exp_t        exp_q[$];
  logic [7:0]  ref_mem [64];
  logic [31:0] slv_mem [16];
  logic        slv_dp_valid, slv_dp_write;
  logic [31:0] slv_dp_addr;
  logic [2:0]  slv_dp_size;
  vec_t        vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] val);
    slv_mem[addr[5:2]] = val;
    for (int b = 0; b < 4; b++) ref_mem[{addr[5:2], 2'b00} + b] = val[8*b +: 8];
  endtask

  // Reference: a command reads/writes 1, 2 or 4 little-endian bytes at its
  // size-aligned address; responses come back in acceptance order.
  task automatic ref_accept();
    exp_t e;
    int   s, na, n;
    s  = (req_size > 3'd2) ? 2 : int'(req_size);
    n  = 1 << s;
    na = int'(req_addr[5:0]) & ~(n - 1);
    e.wr    = req_write;
    e.rdata = 32'd0;
    for (int i = 0; i < n; i++) begin
      if (req_write) ref_mem[na + i] = req_wdata[8*i +: 8];
      else           e.rdata[8*i +: 8] = ref_mem[na + i];
    end
    exp_q.push_back(e);
  endtask

  task automatic slave_write();
    int base, n;
    base = int'(slv_dp_addr[1:0]);
    n    = 1 << slv_dp_size;
    for (int b = 0; b < 4; b++)
      if (b >= base && b < base + n)
        slv_mem[slv_dp_addr[5:2]][8*b +: 8] = HWDATA[8*b +: 8];
  endtask

  // One clock: book-keep what the coming edge does, cross the edge, then
  // drive HRDATA for the new data phase and check responses and wait-state
  // holding.
  task automatic tick();
    logic        hold_a, hold_d;
    logic [31:0] p_haddr, p_hwdata;
    logic [2:0]  p_hsize;
    logic        p_hwrite;
    hold_a   = !HRESET && !HREADY && (HTRANS == 2'b10);
    hold_d   = !HRESET && !HREADY && slv_dp_valid && slv_dp_write;
    p_haddr  = HADDR;
    p_hsize  = HSIZE;
    p_hwrite = HWRITE;
    p_hwdata = HWDATA;
    if (HRESET) begin
      exp_q.delete();
      slv_dp_valid = 1'b0;
      for (int w = 0; w < 16; w++)
        for (int b = 0; b < 4; b++) ref_mem[4*w + b] = slv_mem[w][8*b +: 8];
    end else begin
      if (req_valid && req_ready) ref_accept();
      if (HREADY) begin
        if (slv_dp_valid && slv_dp_write) slave_write();
        slv_dp_valid = (HTRANS == 2'b10);
        slv_dp_write = HWRITE;
        slv_dp_addr  = HADDR;
        slv_dp_size  = HSIZE;
      end
    end
    @(posedge HCLK);
    @(negedge HCLK);
    HRDATA = (slv_dp_valid && !slv_dp_write) ? slv_mem[slv_dp_addr[5:2]] : $urandom();
    #1;
    if (hold_a) begin
      chk("hold_htrans", 32'(HTRANS), 32'd2);
      chk("hold_haddr", HADDR, p_haddr);
      chk("hold_hsize", 32'(HSIZE), 32'(p_hsize));
      chk("hold_hwrite", 32'(HWRITE), 32'(p_hwrite));
    end
    if (hold_d) chk("hold_hwdata", HWDATA, p_hwdata);
    if (rsp_valid) begin
      rsp_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_write", 32'(rsp_write), 32'(e.wr));
        chk("rsp_rdata", rsp_rdata, e.rdata);
      end
    end
  endtask

  task automatic set_req(input logic v, input logic wr, input logic [31:0] a,
                         input logic [2:0] s, input logic [31:0] wd);
    req_valid = v;
    req_write = wr;
    req_addr  = a;
    req_size  = s;
    req_wdata = wd;
  endtask

  task automatic run_single(input vec_t v);
    preload(v.addr, v.preload);
    set_req(1'b1, v.wr, v.addr, v.size, v.wdata);
    HREADY = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("vec_htrans", 32'(HTRANS), 32'd2);
    chk("vec_haddr", HADDR, v.exp_haddr);
    chk("vec_hsize", 32'(HSIZE), 32'(v.exp_hsize));
    chk("vec_hwrite", 32'(HWRITE), 32'(v.wr));
    tick();
    chk("vec_hwdata", HWDATA, v.wr ? v.exp_hwdata : 32'd0);
    chk("vec_idle", 32'(HTRANS), 32'd0);
    tick();
    chk("vec_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("vec_rsp_write", 32'(rsp_write), 32'(v.wr));
    chk("vec_rsp_rdata", rsp_rdata, v.exp_rdata);
    tick();
    chk("vec_rsp_pulse", 32'(rsp_valid), 32'd0);
    chk("vec_busy_done", 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h04, 3'd2, 32'hDEADBEEF, 32'h0,        32'h04, 3'd2, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 32'h13, 3'd0, 32'h0,        32'hAABBCCDD, 32'h13, 3'd0, 32'h0,        32'h000000AA};
    vecs[2] = '{1'b0, 32'h12, 3'd1, 32'h0,        32'hAABBCCDD, 32'h12, 3'd1, 32'h0,        32'h0000AABB};
    vecs[3] = '{1'b1, 32'h11, 3'd0, 32'hFFFFFF5A, 32'h0,        32'h11, 3'd0, 32'h5A5A5A5A, 32'h0};
    vecs[4] = '{1'b1, 32'h17, 3'd1, 32'hFFFF1234, 32'h0,        32'h16, 3'd1, 32'h12341234, 32'h0};
    vecs[5] = '{1'b0, 32'h1B, 3'd3, 32'h0,        32'h01234567, 32'h18, 3'd2, 32'h0,        32'h01234567};
    vecs[6] = '{1'b0, 32'h10, 3'd0, 32'h0,        32'hAABBCCDD, 32'h10, 3'd0, 32'h0,        32'h000000DD};
    vecs[7] = '{1'b0, 32'h11, 3'd1, 32'h0,        32'hAABBCCDD, 32'h10, 3'd1, 32'h0,        32'h0000CCDD};
    vecs[8] = '{1'b1, 32'h2A, 3'd7, 32'hCAFE0001, 32'h0,        32'h28, 3'd2, 32'hCAFE0001, 32'h0};
    vecs[9] = '{1'b0, 32'h12, 3'd0, 32'h0,        32'hAABBCCDD, 32'h12, 3'd0, 32'h0,        32'h000000BB};

    for (int w = 0; w < 16; w++) slv_mem[w] = 32'd0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'd0;
    slv_dp_valid = 1'b0;
    slv_dp_write = 1'b0;
    slv_dp_addr  = 32'd0;
    slv_dp_size  = 3'd0;
    set_req(1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
    HREADY = 1'b1;
    HRDATA = 32'd0;
    HRESET = 1'b1;

    // Reset state
    repeat (3) tick();
    chk("rst_htrans", 32'(HTRANS), 32'd0);
    chk("rst_haddr", HADDR, 32'd0);
    chk("rst_hsize", 32'(HSIZE), 32'd0);
    chk("rst_hwrite", 32'(HWRITE), 32'd0);
    chk("rst_hwdata", HWDATA, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    HRESET = 1'b0;
    #1;
    chk("ready_after_reset", 32'(req_ready), 32'd1);

    // Table of single zero-wait transfers
    for (int i = 0; i < 10; i++) run_single(vecs[i]);

    // Four back-to-back word reads
    for (int k = 0; k < 4; k++) preload(32'h20 + 32'(4*k), 32'hA0A0_0000 + 32'(k));
    for (int k = 0; k < 8; k++) begin
      if (k < 4) set_req(1'b1, 1'b0, 32'h20 + 32'(4*k), 3'd2, 32'd0);
      else       req_valid = 1'b0;
      HREADY = 1'b1;
      if (k < 4) chk("b2b_ready", 32'(req_ready), 32'd1);
      tick();
      chk("b2b_htrans", 32'(HTRANS), (k < 4) ? 32'd2 : 32'd0);
      if (k < 4) chk("b2b_haddr", HADDR, 32'h20 + 32'(4*k));
      chk("b2b_rsp_valid", 32'(rsp_valid), (k >= 2 && k <= 5) ? 32'd1 : 32'd0);
      if (k >= 2 && k <= 5) chk("b2b_rdata", rsp_rdata, 32'hA0A0_0000 + 32'(k - 2));
    end

    // Wait states during a write data phase, FIFO filling to two entries
    preload(32'h34, 32'h55667788);
    preload(32'h38, 32'h99AABBCC);
    set_req(1'b1, 1'b1, 32'h30, 3'd2, 32'hCAFEF00D);
    HREADY = 1'b1;
    tick();
    chk("ws_haddr0", HADDR, 32'h30);
    set_req(1'b1, 1'b0, 32'h34, 3'd2, 32'd0);
    tick();
    chk("ws_haddr1", HADDR, 32'h34);
    chk("ws_hwdata1", HWDATA, 32'hCAFEF00D);
    set_req(1'b1, 1'b0, 32'h38, 3'd2, 32'd0);
    HREADY = 1'b0;
    tick();
    chk("ws_haddr2", HADDR, 32'h34);
    chk("ws_hwdata2", HWDATA, 32'hCAFEF00D);
    chk("ws_full_ready", 32'(req_ready), 32'd0);
    chk("ws_rsp2", 32'(rsp_valid), 32'd0);
    set_req(1'b1, 1'b1, 32'h3C, 3'd2, 32'h0BADCAFE);
    tick();
    chk("ws_haddr3", HADDR, 32'h34);
    chk("ws_hwdata3", HWDATA, 32'hCAFEF00D);
    chk("ws_rsp3", 32'(rsp_valid), 32'd0);
    HREADY = 1'b1;
    chk("ws_full_pop_not_ready", 32'(req_ready), 32'd0);
    tick();
    chk("ws_rsp4", 32'(rsp_valid), 32'd1);
    chk("ws_rsp4_write", 32'(rsp_write), 32'd1);
    chk("ws_haddr4", HADDR, 32'h38);
    chk("ws_hwdata4", HWDATA, 32'd0);
    chk("ws_ready4", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    repeat (8) tick();
    chk("ws_drain", 32'(exp_q.size()), 32'd0);

    // Reset with one transfer in data phase and two queued
    set_req(1'b1, 1'b1, 32'h00, 3'd2, 32'h77777777);
    HREADY = 1'b1;
    tick();
    set_req(1'b1, 1'b0, 32'h04, 3'd2, 32'd0);
    tick();
    set_req(1'b1, 1'b0, 32'h08, 3'd2, 32'd0);
    HREADY = 1'b0;
    tick();
    chk("mr_busy_before", 32'(busy), 32'd1);
    req_valid = 1'b0;
    HREADY = 1'b1;
    HRESET = 1'b1;
    #1;
    chk("mr_ready_in_reset", 32'(req_ready), 32'd0);
    tick();
    HRESET = 1'b0;
    chk("mr_htrans", 32'(HTRANS), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_rsp", 32'(rsp_valid), 32'd0);
    chk("mr_hwdata", HWDATA, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mr_no_rsp", 32'(rsp_valid), 32'd0);
    end
    run_single('{1'b0, 32'h00, 3'd2, 32'h0, 32'h13572468, 32'h00, 3'd2, 32'h0, 32'h13572468});

    // Random traffic with random wait states and one reset in the middle
    rsp_seen = 0;
    for (int n = 0; n < 600; n++) begin
      set_req($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 63)), 3'($urandom_range(0, 7)), $urandom());
      HREADY = ($urandom_range(0, 3) != 0);
      HRESET = (n == 300);
      tick();
    end
    HRESET = 1'b0;
    req_valid = 1'b0;
    HREADY = 1'b1;
    repeat (6) tick();
    chk("rand_drain", 32'(exp_q.size()), 32'd0);
    chk("rand_activity", 32'(rsp_seen > 100), 32'd1);
    for (int w = 0; w < 16; w++)
      chk("rand_mem", slv_mem[w], {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
